// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem
// request at a time and presents registered packets to decode.
module fetch #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          EX_W            = 4,
   parameter int          EX_MISALIGNED   = 0,
   parameter int          EX_ACCESS_FAULT = 1
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [31:0]     imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            imem_resp_error,
   output logic [31:0]     PC_out,
   output logic [31:0]     instr_out,
   output logic [EX_W-1:0] exception_out,
   output logic            exception_out_valid,
   output logic            pipeline_out_valid,
   input  logic            stall,
   input  logic            flush,
   input  logic [31:0]     redirect_pc
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   // MISA: misaligned redirect waiting to emit its exception packet
   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DRAIN,
      S_MISA,
      S_FAULT
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic              mis_q, mis_d;
   logic              hb_v_q, hb_v_d;
   logic [31:0]       hb_pc_q, hb_pc_d;
   logic [31:0]       hb_ins_q, hb_ins_d;
   logic              hb_err_q, hb_err_d;
   logic [31:0]       opc_q, opc_d;
   logic [31:0]       oins_q, oins_d;
   logic [EX_W-1:0]   exc_q, exc_d;
   logic              exv_q, exv_d;
   logic              pv_q, pv_d;

   logic              fire;
   logic              pending;
   logic [31:0]       req_pc;
   logic              ld;
   logic [31:0]       ld_pc;
   logic [31:0]       ld_ins;
   logic              ld_err;
   logic              ld_mis;

   // pc has already advanced past the in-flight request
   assign req_pc = pc_q - 32'd4;
   assign fire   = (state_q == S_REQ) && imem_req_ready;

   assign imem_req_valid      = reset && (state_q == S_REQ);
   assign imem_req_addr       = pc_q;
   assign PC_out              = opc_q;
   assign instr_out           = oins_q;
   assign exception_out       = exc_q;
   assign exception_out_valid = exv_q;
   assign pipeline_out_valid  = pv_q;

   // next-state, hold buffer and output packet selection
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      mis_d    = mis_q;
      hb_v_d   = hb_v_q;
      hb_pc_d  = hb_pc_q;
      hb_ins_d = hb_ins_q;
      hb_err_d = hb_err_q;
      opc_d    = opc_q;
      oins_d   = oins_q;
      exc_d    = exc_q;
      exv_d    = exv_q;
      pv_d     = pv_q;
      pending  = 1'b0;
      ld       = 1'b0;
      ld_pc    = req_pc;
      ld_ins   = imem_resp_data;
      ld_err   = imem_resp_error;
      ld_mis   = 1'b0;
      if (flush) begin
         pending = fire ||
                   (((state_q == S_WAIT) ||
                     (state_q == S_DRAIN)) &&
                    !imem_resp_valid);
         pc_d    = redirect_pc;
         hb_v_d  = 1'b0;
         pv_d    = 1'b0;
         mis_d   = |redirect_pc[1:0];
         if (pending) begin
            state_d = S_DRAIN;
         end else if (mis_d) begin
            state_d = S_MISA;
         end else begin
            state_d = S_REQ;
         end
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (imem_req_ready) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  if (stall) begin
                     hb_v_d   = 1'b1;
                     hb_pc_d  = req_pc;
                     hb_ins_d = imem_resp_data;
                     hb_err_d = imem_resp_error;
                     state_d  = S_HOLD;
                  end else begin
                     ld      = 1'b1;
                     state_d = imem_resp_error ? S_FAULT : S_REQ;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if (hb_v_q) begin
                     ld      = 1'b1;
                     ld_pc   = hb_pc_q;
                     ld_ins  = hb_ins_q;
                     ld_err  = hb_err_q;
                     hb_v_d  = 1'b0;
                     state_d = hb_err_q ? S_FAULT : S_REQ;
                  end else begin
                     state_d = S_REQ;
                  end
               end
            end
            S_DRAIN: begin
               if (imem_resp_valid) begin
                  state_d = mis_q ? S_MISA : S_REQ;
               end
            end
            S_MISA: begin
               if (!stall) begin
                  ld      = 1'b1;
                  ld_mis  = 1'b1;
                  ld_pc   = pc_q;
                  mis_d   = 1'b0;
                  state_d = S_FAULT;
               end
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
            default: begin
               state_d = S_REQ;
            end
         endcase
         if (ld) begin
            pv_d  = 1'b1;
            opc_d = ld_pc;
            if (ld_mis) begin
               oins_d = NOP;
               exc_d  = EX_W'(EX_MISALIGNED);
               exv_d  = 1'b1;
            end else if (ld_err) begin
               oins_d = NOP;
               exc_d  = EX_W'(EX_ACCESS_FAULT);
               exv_d  = 1'b1;
            end else begin
               oins_d = ld_ins;
               exc_d  = '0;
               exv_d  = 1'b0;
            end
         end else if (!stall) begin
            pv_d = 1'b0;
         end
      end
   end

   // state, pc, hold buffer and output packet registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         mis_q    <= 1'b0;
         hb_v_q   <= 1'b0;
         hb_pc_q  <= '0;
         hb_ins_q <= '0;
         hb_err_q <= 1'b0;
         opc_q    <= '0;
         oins_q   <= '0;
         exc_q    <= '0;
         exv_q    <= 1'b0;
         pv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         mis_q    <= mis_d;
         hb_v_q   <= hb_v_d;
         hb_pc_q  <= hb_pc_d;
         hb_ins_q <= hb_ins_d;
         hb_err_q <= hb_err_d;
         opc_q    <= opc_d;
         oins_q   <= oins_d;
         exc_q    <= exc_d;
         exv_q    <= exv_d;
         pv_q     <= pv_d;
      end
   end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_error;
   logic [31:0] PC_out;
   logic [31:0] instr_out;
   logic [3:0]  exception_out;
   logic        exception_out_valid;
   logic        pipeline_out_valid;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   fetch dut (
      .clk                 (clk),
      .reset               (reset),
      .imem_req_valid      (imem_req_valid),
      .imem_req_ready      (imem_req_ready),
      .imem_req_addr       (imem_req_addr),
      .imem_resp_valid     (imem_resp_valid),
      .imem_resp_data      (imem_resp_data),
      .imem_resp_error     (imem_resp_error),
      .PC_out              (PC_out),
      .instr_out           (instr_out),
      .exception_out       (exception_out),
      .exception_out_valid (exception_out_valid),
      .pipeline_out_valid  (pipeline_out_valid),
      .stall               (stall),
      .flush               (flush),
      .redirect_pc         (redirect_pc)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model: fetch address, in-flight request, hold slot, halt
   logic [31:0] m_pc;
   logic        m_busy;
   logic [31:0] m_busy_pc;
   logic        m_drop;
   logic        m_halt;
   logic        m_mis;
   logic        m_buf_v;
   logic [31:0] m_buf_pc;
   logic [31:0] m_buf_ins;
   logic        m_buf_err;
   logic [31:0] o_pc;
   logic [31:0] o_ins;
   logic [3:0]  o_exc;
   logic        o_exv;
   logic        o_pv;

   // memory: one pending response with a countdown
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic        mem_err;
   int          t_lat;
   int          err_pct;
   logic [31:0] fault_addr;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   function automatic logic m_req();
      return !m_busy && !m_buf_v && !m_halt && !m_mis;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h00A0_0113;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic m_reset();
      m_pc    = 32'h0;
      m_busy  = 1'b0;
      m_busy_pc = 32'h0;
      m_drop  = 1'b0;
      m_halt  = 1'b0;
      m_mis   = 1'b0;
      m_buf_v = 1'b0;
      m_buf_pc  = 32'h0;
      m_buf_ins = 32'h0;
      m_buf_err = 1'b0;
      o_pc  = 32'h0;
      o_ins = 32'h0;
      o_exc = 4'h0;
      o_exv = 1'b0;
      o_pv  = 1'b0;
   endtask

   task automatic present(input logic [31:0] pc,
                          input logic [31:0] ins,
                          input logic err, input logic mis);
      o_pc = pc;
      o_pv = 1'b1;
      if (mis) begin
         o_ins = NOP; o_exc = 4'd0; o_exv = 1'b1;
      end else if (err) begin
         o_ins = NOP; o_exc = 4'd1; o_exv = 1'b1;
      end else begin
         o_ins = ins; o_exc = 4'd0; o_exv = 1'b0;
      end
   endtask

   task automatic m_step(input logic s, input logic f,
                         input logic [31:0] rp, input logic rdy,
                         input logic rv, input logic [31:0] rd,
                         input logic re);
      logic acc;
      logic got;
      logic mis_go;
      logic [31:0] gpc;
      acc = m_req() && rdy;
      if (f) begin
         m_busy  = (m_busy && !rv) || acc;
         m_drop  = m_busy;
         m_buf_v = 1'b0;
         m_pc    = rp;
         o_pv    = 1'b0;
         m_halt  = 1'b0;
         m_mis   = (rp[1:0] != 2'b00);
      end else begin
         got    = 1'b0;
         gpc    = m_busy_pc;
         mis_go = m_mis && !m_busy;
         if (rv && m_busy) begin
            m_busy = 1'b0;
            if (m_drop) m_drop = 1'b0;
            else begin
               got = 1'b1;
               if (re) m_halt = 1'b1;
            end
         end
         if (!s) begin
            if (m_buf_v) begin
               present(m_buf_pc, m_buf_ins, m_buf_err, 1'b0);
               m_buf_v = 1'b0;
            end else if (got) begin
               present(gpc, rd, re, 1'b0);
            end else if (mis_go) begin
               present(m_pc, NOP, 1'b0, 1'b1);
               m_mis  = 1'b0;
               m_halt = 1'b1;
            end else begin
               o_pv = 1'b0;
            end
         end else if (got) begin
            m_buf_v   = 1'b1;
            m_buf_pc  = gpc;
            m_buf_ins = rd;
            m_buf_err = re;
         end
         if (acc) begin
            m_busy    = 1'b1;
            m_busy_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
   endtask

   task automatic compare();
      chk("req_valid", 32'(imem_req_valid), 32'(m_req()));
      if (m_req()) chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", 32'(pipeline_out_valid), 32'(o_pv));
      chk("PC_out", PC_out, o_pc);
      chk("instr_out", instr_out, o_ins);
      chk("exc_code", 32'(exception_out), 32'(o_exc));
      chk("exc_valid", 32'(exception_out_valid), 32'(o_exv));
   endtask

   // one clock: drive inputs, advance model and memory, then check
   task automatic step(input logic s, input logic f,
                       input logic [31:0] rp, input logic rdy);
      logic rv;
      logic re;
      logic [31:0] rd;
      logic acc;
      logic [31:0] aaddr;
      rv = (mem_cnt == 1);
      rd = rv ? mem_word(mem_addr) : $urandom;
      re = rv ? mem_err : 1'($urandom_range(0, 1));
      stall           = s;
      flush           = f;
      redirect_pc     = rp;
      imem_req_ready  = rdy;
      imem_resp_valid = rv;
      imem_resp_data  = rd;
      imem_resp_error = re;
      acc   = m_req() && rdy;
      aaddr = m_pc;
      m_step(s, f, rp, rdy, rv, rd, re);
      if (mem_cnt > 0) mem_cnt--;
      if (acc) begin
         mem_cnt  = t_lat;
         mem_addr = aaddr;
         mem_err  = (aaddr == fault_addr) ||
                    ($urandom_range(0, 99) < err_pct);
      end
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      reset           = 1'b0;
      stall           = 1'b0;
      flush           = 1'b0;
      redirect_pc     = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_error = 1'b0;
      m_reset();
      mem_cnt = 0;
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_out_valid", 32'(pipeline_out_valid), 32'h0);
      chk("rst_exc_valid", 32'(exception_out_valid), 32'h0);
      chk("rst_PC_out", PC_out, 32'h0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_exc", 32'(exception_out), 32'h0);
      reset = 1'b1;
      #1;
      chk("rel_req_valid", 32'(imem_req_valid), 32'h1);
      chk("rel_req_addr", imem_req_addr, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      logic s, f, rdy;
      logic [31:0] rp;
      reset      = 1'b0;
      t_lat      = 1;
      err_pct    = 0;
      fault_addr = 32'h40;
      do_reset();

      // two sequential fetches, 1-cycle memory
      step(0, 0, 0, 1);
      chk("f0_valid_gap", 32'(pipeline_out_valid), 32'h0);
      step(0, 0, 0, 1);
      chk("f0_valid", 32'(pipeline_out_valid), 32'h1);
      chk("f0_pc", PC_out, 32'h0);
      chk("f0_instr", instr_out, 32'h0050_0093);
      chk("f0_exv", 32'(exception_out_valid), 32'h0);
      chk("f1_addr", imem_req_addr, 32'h4);
      step(0, 0, 0, 1);
      chk("f0_one_cycle", 32'(pipeline_out_valid), 32'h0);
      step(0, 0, 0, 1);
      chk("f1_pc", PC_out, 32'h4);
      chk("f1_instr", instr_out, 32'h00A0_0113);

      // ready low for three cycles at 0x8
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         chk("rdy_lo_valid", 32'(imem_req_valid), 32'h1);
         chk("rdy_lo_addr", imem_req_addr, 32'h8);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("f2_pc", PC_out, 32'h8);
      chk("f3_addr", imem_req_addr, 32'hC);

      // stall across the 0xC response
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 1);
         chk("stall_valid", 32'(pipeline_out_valid), 32'h1);
         chk("stall_pc", PC_out, 32'h8);
         chk("stall_noreq", 32'(imem_req_valid), 32'h0);
      end
      step(0, 0, 0, 1);
      chk("unstall_valid", 32'(pipeline_out_valid), 32'h1);
      chk("unstall_pc", PC_out, 32'hC);

      // flush while 0x10 is in flight
      t_lat = 3;
      step(0, 0, 0, 1);
      step(0, 1, 32'h100, 1);
      chk("flush_valid", 32'(pipeline_out_valid), 32'h0);
      chk("flush_noreq", 32'(imem_req_valid), 32'h0);
      waited = 0;
      while (!imem_req_valid && waited < 10) begin
         step(0, 0, 0, 1);
         waited++;
         chk("drain_valid", 32'(pipeline_out_valid), 32'h0);
      end
      chk("drain_done", 32'(imem_req_valid), 32'h1);
      chk("redir_addr", imem_req_addr, 32'h100);
      t_lat = 1;

      // misaligned redirect
      step(0, 1, 32'h102, 0);
      chk("mis_noreq", 32'(imem_req_valid), 32'h0);
      step(0, 0, 0, 1);
      chk("mis_valid", 32'(pipeline_out_valid), 32'h1);
      chk("mis_pc", PC_out, 32'h102);
      chk("mis_instr", instr_out, NOP);
      chk("mis_exc", 32'(exception_out), 32'h0);
      chk("mis_exv", 32'(exception_out_valid), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1);
         chk("fault_noreq", 32'(imem_req_valid), 32'h0);
      end
      step(0, 1, 32'h200, 1);
      chk("refetch_addr", imem_req_addr, 32'h200);

      // access fault at 0x40
      step(0, 1, 32'h40, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("af_valid", 32'(pipeline_out_valid), 32'h1);
      chk("af_pc", PC_out, 32'h40);
      chk("af_exc", 32'(exception_out), 32'h1);
      chk("af_exv", 32'(exception_out_valid), 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1);
         chk("af_halt", 32'(imem_req_valid), 32'h0);
      end

      // pc wrap in a fresh run
      do_reset();
      step(0, 1, 32'hFFFF_FFFC, 0);
      chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("wrap_pc", PC_out, 32'hFFFF_FFFC);
      chk("wrap_addr1", imem_req_addr, 32'h0);

      // randomized traffic
      err_pct = 3;
      for (int i = 0; i < 4000; i++) begin
         if (i % 1000 == 999) do_reset();
         s   = ($urandom_range(0, 99) < 25);
         f   = ($urandom_range(0, 99) < 4);
         rdy = ($urandom_range(0, 99) < 70);
         rp  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         if ($urandom_range(0, 9) == 0)
            rp = rp + 32'($urandom_range(1, 3));
         t_lat = $urandom_range(1, 3);
         step(s, f, rp, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
